// File: rtl/memory_home_if.sv
// Ring-side request/response channels and RAM-side port bundle for the home directory controller.
// The slave modport is the controller's view; the master modport is the ring/RAM environment's view.
interface memory_home_if #(
  parameter int DIR_W  = 4,
  parameter int LINE_W = 128
);
  localparam int ID_W = $clog2(DIR_W);
  localparam int ST_W = DIR_W + 2;

  logic              req_valid_in;
  logic              req_ready_out;
  logic [1:0]        req_type_in;
  logic [ID_W-1:0]   req_src_in;
  logic [31:0]       req_addr_in;
  logic [LINE_W-1:0] req_data_in;

  logic              resp_valid_out;
  logic              resp_ready_in;
  logic [1:0]        resp_type_out;
  logic [DIR_W-1:0]  resp_dst_out;
  logic [31:0]       resp_addr_out;
  logic [LINE_W-1:0] resp_data_out;

  logic [31:0]       addr_out;
  logic              state_re_out;
  logic              state_we_out;
  logic              data_re_out;
  logic              data_we_out;
  logic [ST_W-1:0]   state_wdata_out;
  logic [LINE_W-1:0] data_wdata_out;
  logic [ST_W-1:0]   state_rdata_in;
  logic [LINE_W-1:0] data_rdata_in;

  modport slave (
    input  req_valid_in, req_type_in, req_src_in, req_addr_in, req_data_in,
    output req_ready_out,
    output resp_valid_out, resp_type_out, resp_dst_out, resp_addr_out, resp_data_out,
    input  resp_ready_in,
    output addr_out, state_re_out, state_we_out, data_re_out, data_we_out,
    output state_wdata_out, data_wdata_out,
    input  state_rdata_in, data_rdata_in
  );

  modport master (
    output req_valid_in, req_type_in, req_src_in, req_addr_in, req_data_in,
    input  req_ready_out,
    input  resp_valid_out, resp_type_out, resp_dst_out, resp_addr_out, resp_data_out,
    output resp_ready_in,
    input  addr_out, state_re_out, state_we_out, data_re_out, data_we_out,
    input  state_wdata_out, data_wdata_out,
    output state_rdata_in, data_rdata_in
  );
endinterface

// File: rtl/memory_home_ctrl.sv
// Home-node directory controller: one line transaction at a time, directory lookup,
// invalidation of conflicting sharers/owner, and data/ack responses back to the ring.
module memory_home_ctrl #(
  parameter int DIR_W  = 4,
  parameter int LINE_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  memory_home_if.slave        bus,
  output logic [2:0]          dbg_state
);
  localparam int ID_W = $clog2(DIR_W);
  localparam int ST_W = DIR_W + 2;

  typedef logic [DIR_W-1:0] dir_t;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_INV, S_WAIT_ACK, S_RESP} state_e;

  localparam logic [1:0] RD_SH = 2'b00, RD_EX = 2'b01, WB = 2'b10, INV_ACK = 2'b11;
  localparam logic [1:0] T_DATA_SH = 2'b00, T_DATA_EX = 2'b01, T_WB_ACK = 2'b10, T_INV = 2'b11;
  localparam logic [1:0] H_R = 2'b00, H_W = 2'b01, H_TR = 2'b10, H_TW = 2'b11;

  // Handshake: a request transfers when req_valid_in && req_ready_out on a rising edge;
  // a response transfers when resp_valid_out && resp_ready_in on a rising edge.
  state_e            state_q, state_d;
  logic [1:0]        type_q;
  logic [ID_W-1:0]   src_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wb_data_q;
  logic [1:0]        resp_type_q;
  logic [LINE_W-1:0] resp_data_q;
  dir_t              pending_q;
  logic              owner_flag_q;

  logic              ready;
  logic              req_fire;
  logic              req_accept;
  dir_t              m;

  logic              lk_is_w;
  logic              lk_own;
  logic              lk_conflict;
  logic              lk_swe;
  logic              lk_dwe;
  logic [ST_W-1:0]   lk_swdata;
  logic [1:0]        lk_rtype;
  dir_t              lk_pending;
  dir_t              lk_dir;
  logic [ID_W-1:0]   lk_owner;

  logic              ack_hit;
  logic              ack_done;
  dir_t              pending_nxt;
  logic [ST_W-1:0]   final_state;

  assign ready = (state_q == S_IDLE) ? !rst
               : (state_q == S_WAIT_ACK) && (bus.req_type_in == INV_ACK);
  assign req_fire   = bus.req_valid_in && ready;
  assign req_accept = req_fire && (state_q == S_IDLE) && (bus.req_type_in != INV_ACK);
  assign m          = dir_t'(1) << src_q;
  assign dbg_state  = state_q;

  // Lookup decode; TR/TW found here is read as R with the same low bits.
  always_comb begin
    lk_dir      = bus.state_rdata_in[DIR_W-1:0];
    lk_owner    = bus.state_rdata_in[ID_W-1:0];
    lk_is_w     = (bus.state_rdata_in[ST_W-1:DIR_W] == H_W);
    lk_own      = lk_is_w && (lk_owner == src_q);
    lk_pending  = lk_is_w ? (dir_t'(1) << lk_owner) : (lk_dir & ~m);
    lk_conflict = 1'b0;
    lk_swe      = 1'b0;
    lk_dwe      = 1'b0;
    lk_swdata   = '0;
    lk_rtype    = T_WB_ACK;
    case (type_q)
      WB: begin
        if (lk_own) begin
          lk_swe = 1'b1;
          lk_dwe = 1'b1;
        end
      end
      RD_SH: begin
        lk_rtype = T_DATA_SH;
        if (!lk_is_w) begin
          lk_swe    = 1'b1;
          lk_swdata = {H_R, lk_dir | m};
        end else if (lk_own) begin
          lk_swe    = 1'b1;
          lk_swdata = {H_R, m};
        end else begin
          lk_conflict = 1'b1;
        end
      end
      RD_EX: begin
        lk_rtype = T_DATA_EX;
        if (!lk_is_w && ((lk_dir & ~m) == '0)) begin
          lk_swe    = 1'b1;
          lk_swdata = {H_W, {(DIR_W-ID_W){1'b0}}, src_q};
        end else if (!lk_own) begin
          lk_conflict = 1'b1;
        end
      end
      default: ;
    endcase
    if (lk_conflict) begin
      lk_swe    = 1'b1;
      lk_swdata = {(type_q == RD_SH) ? H_TR : H_TW, lk_pending};
    end
  end

  assign ack_hit     = req_fire && (state_q == S_WAIT_ACK) && pending_q[bus.req_src_in];
  assign pending_nxt = pending_q & ~(dir_t'(1) << bus.req_src_in);
  assign ack_done    = ack_hit && (pending_nxt == '0);
  assign final_state = (type_q == RD_SH) ? {H_R, m} : {H_W, {(DIR_W-ID_W){1'b0}}, src_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_accept) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = lk_conflict ? S_INV : S_RESP;
      S_INV:      if (bus.resp_ready_in) state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (ack_done) state_d = S_RESP;
      S_RESP:     if (bus.resp_ready_in) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_out   = ready;
    bus.resp_valid_out  = 1'b0;
    bus.resp_type_out   = '0;
    bus.resp_dst_out    = '0;
    bus.resp_addr_out   = '0;
    bus.resp_data_out   = '0;
    bus.addr_out        = addr_q;
    bus.state_re_out    = 1'b0;
    bus.data_re_out     = 1'b0;
    bus.state_we_out    = 1'b0;
    bus.data_we_out     = 1'b0;
    bus.state_wdata_out = '0;
    bus.data_wdata_out  = '0;
    case (state_q)
      S_IDLE: begin
        bus.addr_out     = rst ? '0 : bus.req_addr_in;
        bus.state_re_out = req_accept;
        bus.data_re_out  = req_accept;
      end
      S_LOOKUP: begin
        bus.state_we_out    = lk_swe;
        bus.state_wdata_out = lk_swdata;
        bus.data_we_out     = lk_dwe;
        bus.data_wdata_out  = lk_dwe ? wb_data_q : '0;
      end
      S_INV: begin
        bus.resp_valid_out = 1'b1;
        bus.resp_type_out  = T_INV;
        bus.resp_dst_out   = pending_q;
        bus.resp_addr_out  = addr_q;
      end
      S_WAIT_ACK: begin
        if (ack_hit && owner_flag_q) begin
          bus.data_we_out    = 1'b1;
          bus.data_wdata_out = bus.req_data_in;
        end
        if (ack_done) begin
          bus.state_we_out    = 1'b1;
          bus.state_wdata_out = final_state;
        end
      end
      S_RESP: begin
        bus.resp_valid_out = 1'b1;
        bus.resp_type_out  = resp_type_q;
        bus.resp_dst_out   = m;
        bus.resp_addr_out  = addr_q;
        bus.resp_data_out  = resp_data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q       <= '0;
      src_q        <= '0;
      addr_q       <= '0;
      wb_data_q    <= '0;
      resp_type_q  <= '0;
      resp_data_q  <= '0;
      pending_q    <= '0;
      owner_flag_q <= 1'b0;
    end else begin
      if (req_accept) begin
        type_q    <= bus.req_type_in;
        src_q     <= bus.req_src_in;
        addr_q    <= bus.req_addr_in;
        wb_data_q <= bus.req_data_in;
      end
      if (state_q == S_LOOKUP) begin
        resp_type_q  <= lk_rtype;
        resp_data_q  <= (lk_rtype == T_WB_ACK) ? '0 : bus.data_rdata_in;
        owner_flag_q <= lk_conflict && lk_is_w;
        if (lk_conflict) pending_q <= lk_pending;
      end
      // Owner writeback data on the ack replaces the stale RAM copy in the response.
      if (ack_hit) begin
        pending_q <= pending_nxt;
        if (owner_flag_q) resp_data_q <= bus.req_data_in;
      end
    end
  end
endmodule

// File: doc/memory_home_ctrl.md
# memory_home_ctrl

Home-node directory controller sitting directly upstream of the home memory's state/data RAM pair. It accepts coherence requests from the ring (read-shared, read-exclusive, writeback, invalidate-ack) and sequences directory lookups and updates plus data reads and writes into the 128-entry state RAM and data RAM. It issues invalidations when a request conflicts with the current sharers or owner, and returns data or acknowledgement responses. It serialises requests: at most one line transaction is in flight at a time.

## Interface
- DIR_W, 4, directory bitmap width, one bit per core. Core id is 2 bits.
- LINE_W, 128, cache-line width in bits.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_in / req_ready_out  in/out  1  request handshake; a transfer occurs when both are high on a clk edge.
- req_type_in  in  2  00 RD_SH, 01 RD_EX, 10 WB, 11 INV_ACK.
- req_src_in  in  2  requesting core id.
- req_addr_in  in  32  line address; addr[10:4] is the RAM index.
- req_data_in  in  128  WB data, or owner data on INV_ACK.
- resp_valid_out / resp_ready_in  out/in  1  response handshake.
- resp_type_out  out  2  00 DATA_SH, 01 DATA_EX, 10 WB_ACK, 11 INV.
- resp_dst_out  out  4  one-hot or multicast destination mask.
- resp_addr_out, resp_data_out  out  32/128  line address and data.
- addr_out  out  32  RAM address.
- state_re_out, state_we_out, data_re_out, data_we_out  out  1  RAM enables.
- state_wdata_out, data_wdata_out  out  6/128  RAM write data.
- state_rdata_in, data_rdata_in  in  6/128  RAM read data; valid the cycle after a read enable (synchronous read).

## Operation
- Directory encoding: state[5:4] is the home state. 00 R: [3:0] is the sharer bitmap. 01 W: [1:0] is the owner id. 10 TR and 11 TW: [3:0] is the pending-ack mask. RAM initialises to all zeros, i.e. R with no sharers.
- FSM states: IDLE, LOOKUP, INV, WAIT_ACK, RESP.
- IDLE
  - req_ready_out=1.
  - On transfer of RD_SH, RD_EX or WB: latch type, src, addr and data; drive addr_out=req_addr_in, state_re_out=1 and data_re_out=1; go to LOOKUP.
  - INV_ACK accepted in IDLE is dropped.
- LOOKUP (RAM data valid). Let m = 1<<src.
  - WB, state W with owner==src: write data_in; state becomes R/0000; respond WB_ACK.
  - WB, any other state: stale; no write; respond WB_ACK.
  - RD_SH, state R: state becomes R/(dir|m); respond DATA_SH.
  - RD_SH, state W with owner==src: state becomes R/m; respond DATA_SH.
  - RD_EX, state R with (dir&~m)==0: state becomes W/src; respond DATA_EX.
  - RD_EX, state W with owner==src: no write; respond DATA_EX.
  - Otherwise, conflict:
    - pending = R ? dir&~m : (1<<owner).
    - Set the owner_flag register if the state was W.
    - Write state TR (RD_SH) or TW (RD_EX) with [3:0]=pending.
    - Go to INV.
  - A TR/TW value found in LOOKUP is treated as R with the same [3:0].
  - Response data is latched from data_rdata_in (WB_ACK: zero). Non-conflict cases go to RESP.
- INV
  - resp_valid_out=1, type INV, dst=pending, data=0.
  - On the handshake, go to WAIT_ACK.
- WAIT_ACK
  - req_ready_out = (req_type_in==11).
  - On an INV_ACK with its src bit set in pending: clear that bit.
  - If owner_flag is set, also write req_data_in to the data RAM and to the latched response data.
  - Acks from non-pending sources are consumed and ignored.
  - When pending reaches 0 (in the same cycle as the last ack): write the final state, R/m for RD_SH or W/src for RD_EX, and go to RESP.
- RESP
  - resp_valid_out=1 with the latched type, dst=m, addr and data. All are held stable until resp_ready_in.
  - On the handshake, go to IDLE.
- addr_out is req_addr_in in IDLE and the latched address elsewhere.

## Timing
- Reset: FSM goes to IDLE and all registers clear. Every output is 0 during rst, including req_ready_out. After rst deasserts, req_ready_out=1.
- A reset mid-transaction abandons it with no further RAM writes. A TR/TW value already written remains and is later treated as R.
- Non-conflict latency: request accepted at edge N, RAM update at edge N+1, resp_valid_out high after edge N+1. Next request can be accepted one cycle after the response handshake.
- Conflict: INV valid after edge N+1. Final state write and RESP begin on the edge of the last ack.
- RAM write enables are single-cycle pulses. State and data writes for the same event occur in the same cycle.
- Response outputs hold stable under backpressure; there is no combinational path from resp_ready_in to resp_valid_out.

## Test plan
- Reset, then RD_SH src=2 addr=0x30 with RAM zero: DATA_SH to dst=0100 after 2 cycles. State[3] idx becomes 6'b000100.
- RD_EX src=1 on R/0101: INV to dst=0101. Acks from 0 and 2 lead to a state write 01_0001 and DATA_EX to dst=0010. An ack from core 3 in between is ignored.
- RD_SH src=0 on W owner 3: INV dst=1000. Ack data 0xA5..A5 is written to RAM. DATA_SH carries 0xA5..A5 and the state becomes R/0001.
- WB src=3 on W/3 writes data and sets R/0000, then WB_ACK. WB src=2 on the same line gives WB_ACK with no RAM write.
- Hold resp_ready_in=0 for 5 cycles: outputs stay stable, and no new request is accepted.
- Assert rst in WAIT_ACK: all outputs go to 0 immediately. The next RD_SH to the same line sees TR, treats it as R, and completes normally.
